// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder and the CPU pipeline that drives it:
// request opcodes and the 32-bit data word type.
package mem_responder_pkg;

   typedef logic [31:0] word_t;

   // Request opcode carried on op_in
   localparam logic CACHE_READ  = 1'b0;
   localparam logic CACHE_WRITE = 1'b1;

   // Width of an occupancy counter that must hold values 0..depth inclusive
   function automatic int unsigned count_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between a requester (CPU pipeline) and the memory responder.
//
// Handshake: a transfer happens on a rising clk edge where the producer's valid
// and the consumer's ready are both 1. The request channel is valid_in/ready_in
// (requester produces); the response channel is valid_out/ready_out (responder
// produces). Once valid_out is raised, the responder holds it and data_out
// steady until the transfer completes. ready_in never depends on valid_in.
interface mem_responder_if;
   import mem_responder_pkg::*;

   logic  valid_in;
   logic  ready_in;
   word_t addr_in;
   logic  op_in;
   word_t write_data_in;
   logic  valid_out;
   logic  ready_out;
   word_t data_out;

   modport master (
      output valid_in, addr_in, op_in, write_data_in, ready_out,
      input  ready_in, valid_out, data_out
   );

   modport slave (
      input  valid_in, addr_in, op_in, write_data_in, ready_out,
      output ready_in, valid_out, data_out
   );

endinterface

// File: rtl/mem_responder_resp_fifo.sv
// Synchronous FIFO holding read responses until the requester consumes them.
// Push into a full FIFO and pop from an empty one are ignored.
module resp_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                                         clk,
   input  logic                                         reset,
   input  logic                                         push_i,
   input  logic [WIDTH-1:0]                             push_data_i,
   input  logic                                         pop_i,
   output logic [WIDTH-1:0]                             pop_data_o,
   output logic                                         full_o,
   output logic                                         empty_o,
   output logic [mem_responder_pkg::count_width(DEPTH)-1:0] count_o
);
   import mem_responder_pkg::*;

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = count_width(DEPTH);
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign full_o     = (count_q == FULL_COUNT);
   assign empty_o    = (count_q == '0);
   assign count_o    = count_q;
   assign pop_data_o = mem_q[rd_ptr_q];
   assign do_push    = push_i & ~full_o;
   assign do_pop     = pop_i & ~empty_o;

   // Next pointers and occupancy; push+pop together leave the count unchanged
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; contents need no reset because occupancy gates visibility
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/mem_responder.sv
// Word-addressed memory model answering CPU requests. Writes are posted, reads
// are returned in order after a fixed latency through a small response FIFO.
// ready_in is a credit check: every accepted read owns a FIFO slot from the
// moment it is accepted until the requester consumes its response, so the FIFO
// can never overflow no matter how long the requester stalls.
module mem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2,
   parameter int RESP_QDEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   mem_responder_if.slave   bus
);
   import mem_responder_pkg::*;

   localparam int IDX_W  = $clog2(DEPTH_WORDS);
   localparam int CRED_W = count_width(RESP_QDEPTH);
   localparam logic [CRED_W-1:0] MAX_CREDITS = CRED_W'(RESP_QDEPTH);

   // Backing array; intentionally not reset so contents survive a reset
   word_t            mem_q [DEPTH_WORDS];
   logic [IDX_W-1:0] word_idx;
   word_t            rd_word;

   logic              accept, rd_accept, wr_accept;
   logic              resp_pop;
   logic              push_valid;
   word_t             push_data;
   word_t             fifo_head;
   logic              fifo_full, fifo_empty;
   logic [CRED_W-1:0] fifo_count;
   logic [CRED_W-1:0] credit_q, credit_d;

   // Byte address to word index; upper bits and byte offset fold away
   assign word_idx  = bus.addr_in[IDX_W+1:2];
   assign rd_word   = mem_q[word_idx];

   assign bus.ready_in = ~reset & (credit_q < MAX_CREDITS);
   assign accept       = bus.valid_in & bus.ready_in;
   assign rd_accept    = accept & (bus.op_in == CACHE_READ);
   assign wr_accept    = accept & (bus.op_in == CACHE_WRITE);

   assign bus.valid_out = ~reset & ~fifo_empty;
   assign bus.data_out  = fifo_head;
   assign resp_pop      = bus.valid_out & bus.ready_out;

   // Posted write into the array at the acceptance edge
   always_ff @(posedge clk) begin
      if (wr_accept) mem_q[word_idx] <= bus.write_data_in;
   end

   // Latency pipeline: LATENCY-1 valid+data stages between array and FIFO
   generate
      if (LATENCY == 1) begin : g_no_pipe
         assign push_valid = rd_accept;
         assign push_data  = rd_word;
      end else begin : g_pipe
         localparam int STAGES = LATENCY - 1;
         logic [STAGES-1:0] pipe_vld_q;
         word_t             pipe_dat_q [STAGES];

         // Valid bits shift toward the FIFO and are cleared by reset
         always_ff @(posedge clk) begin
            if (reset) begin
               pipe_vld_q <= '0;
            end else begin
               pipe_vld_q[0] <= rd_accept;
               for (int i = 1; i < STAGES; i++) pipe_vld_q[i] <= pipe_vld_q[i-1];
            end
         end

         // Data rides alongside its valid bit; qualified by it downstream
         always_ff @(posedge clk) begin
            pipe_dat_q[0] <= rd_word;
            for (int i = 1; i < STAGES; i++) pipe_dat_q[i] <= pipe_dat_q[i-1];
         end

         assign push_valid = pipe_vld_q[STAGES-1];
         assign push_data  = pipe_dat_q[STAGES-1];
      end
   endgenerate

   resp_fifo #(
      .WIDTH (32),
      .DEPTH (RESP_QDEPTH)
   ) u_resp_fifo (
      .clk         (clk),
      .reset       (reset),
      .push_i      (push_valid),
      .push_data_i (push_data),
      .pop_i       (resp_pop),
      .pop_data_o  (fifo_head),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .count_o     (fifo_count)
   );

   // Credits in use = reads accepted but not yet consumed (pipeline + FIFO)
   always_comb begin
      credit_d = credit_q;
      case ({rd_accept, resp_pop})
         2'b10:   credit_d = credit_q + 1'b1;
         2'b01:   credit_d = credit_q - 1'b1;
         default: credit_d = credit_q;
      endcase
   end

   // Credit register; reset discards every outstanding read
   always_ff @(posedge clk) begin
      if (reset) credit_q <= '0;
      else       credit_q <= credit_d;
   end

   // Status and address bits the datapath does not need
   logic unused_bits;
   assign unused_bits = ^{fifo_full, fifo_count, bus.addr_in[31:IDX_W+2], bus.addr_in[1:0]};

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations and a random phase.
module tb_mem_responder;
   import mem_responder_pkg::*;

   localparam int L  = 2;
   localparam int QD = 4;
   localparam int DW = 1024;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mem_responder_if bus();

   mem_responder #(
      .DEPTH_WORDS (DW),
      .LATENCY     (L),
      .RESP_QDEPTH (QD)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      bus.valid_in      = 1'b0;
      bus.op_in         = CACHE_READ;
      bus.addr_in       = '0;
      bus.write_data_in = '0;
   endtask

   task automatic drive_req(input logic op, input logic [31:0] addr, input logic [31:0] data);
      bus.valid_in      = 1'b1;
      bus.op_in         = op;
      bus.addr_in       = addr;
      bus.write_data_in = data;
   endtask

   // ---------------- reference model / scoreboard ----------------
   // Each accepted read is queued with the edge number from which it may be
   // consumed (acceptance edge + LATENCY). Outstanding reads = queue size.
   typedef struct {
      logic [31:0] data;
      int          avail;
   } resp_t;

   resp_t       exp_q[$];
   logic [31:0] mem_m [DW];
   int          edge_no = 0;

   function automatic int idx_of(input logic [31:0] a);
      return int'((a >> 2) % DW);
   endfunction

   // Compare at the falling edge, then advance the model across the next rising edge
   initial begin
      logic exp_ready, exp_valid;
      forever begin
         @(negedge clk);
         edge_no++;
         exp_ready = !reset && (exp_q.size() < QD);
         exp_valid = !reset && (exp_q.size() > 0) && (exp_q[0].avail <= edge_no);
         check("model_ready_in", bus.ready_in, exp_ready);
         check("model_valid_out", bus.valid_out, exp_valid);
         if (exp_valid) check("model_data_out", bus.data_out, exp_q[0].data);
         if (reset) begin
            exp_q.delete();
         end else begin
            if (exp_valid && bus.ready_out) void'(exp_q.pop_front());
            if (bus.valid_in && exp_ready) begin
               if (bus.op_in == CACHE_WRITE) mem_m[idx_of(bus.addr_in)] = bus.write_data_in;
               else exp_q.push_back('{data: mem_m[idx_of(bus.addr_in)], avail: edge_no + L});
            end
         end
      end
   end

   // Hard time limit so the run always ends
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int acc;
      int cyc;
      logic [31:0] seq3 [3];

      reset         = 1'b1;
      bus.ready_out = 1'b0;
      drive_idle();
      repeat (3) tick();
      reset = 1'b0;

      // Reset release: accepting, nothing to return
      @(negedge clk);
      check("post_reset_ready_in", bus.ready_in, 1'b1);
      check("post_reset_valid_out", bus.valid_out, 1'b0);
      tick();

      // Preload every word; words 0..15 hold i+1
      for (int i = 0; i < DW; i++) begin
         drive_req(CACHE_WRITE, 32'(i * 4), (i < 16) ? 32'(i + 1) : $urandom);
         tick();
      end
      drive_idle();
      tick();

      // Write then read same word: response after LATENCY edges
      bus.ready_out = 1'b1;
      drive_req(CACHE_WRITE, 32'h10, 32'hDEADBEEF);
      tick();
      drive_req(CACHE_READ, 32'h10, 32'h0);
      tick();
      drive_idle();
      @(negedge clk);
      check("raw_not_yet_valid", bus.valid_out, 1'b0);
      @(negedge clk);
      check("raw_valid", bus.valid_out, 1'b1);
      check("raw_data", bus.data_out, 32'hDEADBEEF);
      tick();

      // Four back-to-back reads with the consumer stalled, then release
      bus.ready_out = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive_req(CACHE_READ, 32'(i * 4), $urandom);
         tick();
      end
      drive_idle();
      tick();
      tick();
      @(negedge clk);
      check("full_ready_in_low", bus.ready_in, 1'b0);
      check("full_head_data", bus.data_out, 32'd1);
      tick();
      bus.ready_out = 1'b1;
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         check("drain_valid", bus.valid_out, 1'b1);
         check("drain_data", bus.data_out, 32'(j + 1));
      end
      @(negedge clk);
      check("drain_empty", bus.valid_out, 1'b0);
      tick();

      // Full FIFO: pop and blocked request in the same cycle, then acceptance;
      // the new read targets 0x1000, which wraps onto word 0
      bus.ready_out = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive_req(CACHE_READ, 32'((8 + i) * 4), 32'h0);
         tick();
      end
      drive_idle();
      tick();
      tick();
      drive_req(CACHE_READ, 32'h1000, 32'h0);
      bus.ready_out = 1'b1;
      @(negedge clk);
      check("pop_cycle_ready_in", bus.ready_in, 1'b0);
      check("pop_cycle_data", bus.data_out, 32'd9);
      tick();
      @(negedge clk);
      check("reopen_ready_in", bus.ready_in, 1'b1);
      check("reopen_data", bus.data_out, 32'd10);
      tick();
      drive_idle();
      seq3[0] = 32'd11;
      seq3[1] = 32'd12;
      seq3[2] = 32'd1;
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         check("wrap_seq_data", bus.data_out, seq3[j]);
      end
      @(negedge clk);
      check("wrap_seq_empty", bus.valid_out, 1'b0);
      tick();

      // Reset with two reads in flight: nothing stale comes out, array survives
      bus.ready_out = 1'b0;
      drive_req(CACHE_READ, 32'h0, 32'h0);
      tick();
      drive_req(CACHE_READ, 32'h4, 32'h0);
      tick();
      drive_idle();
      reset = 1'b1;
      @(negedge clk);
      check("in_reset_valid_out", bus.valid_out, 1'b0);
      check("in_reset_ready_in", bus.ready_in, 1'b0);
      tick();
      reset         = 1'b0;
      bus.ready_out = 1'b1;
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         check("after_reset_no_stale", bus.valid_out, 1'b0);
      end
      tick();
      drive_req(CACHE_READ, 32'h10, 32'h0);
      tick();
      drive_idle();
      @(negedge clk);
      @(negedge clk);
      check("after_reset_valid", bus.valid_out, 1'b1);
      check("after_reset_data", bus.data_out, 32'hDEADBEEF);
      tick();

      // Random mix of reads/writes with random stalls on both sides
      acc = 0;
      cyc = 0;
      while (acc < 1000 && cyc < 20000) begin
         if ($urandom_range(0, 9) < 7)
            drive_req(logic'($urandom_range(0, 1)),
                      ($urandom_range(0, 1) == 1) ? $urandom : ($urandom & 32'hFFFF_003F),
                      $urandom);
         else
            drive_idle();
         bus.ready_out = ($urandom_range(0, 9) < 6);
         if (bus.valid_in && bus.ready_in) acc++;
         tick();
         cyc++;
      end
      check("random_accepts", 32'(acc), 32'd1000);
      drive_idle();
      bus.ready_out = 1'b1;
      repeat (12) tick();
      @(negedge clk);
      check("final_empty", bus.valid_out, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, meaning number of 32-bit words in the backing array (power of two).
REQ-002 Parameter LATENCY, default 2, meaning edges from request acceptance to response availability (legal range 1..8).
REQ-003 Parameter RESP_QDEPTH, default 4, meaning response FIFO entries (power of two, >= 2).
REQ-004 clk  input  1  clock; reset reset, synchronous, active-high; clock clk.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 valid_in  input  1  requester presents a request.
REQ-007 ready_in  output  1  responder can accept a request this cycle.
REQ-008 addr_in  input  32  byte address; word index = addr_in[log2(DEPTH_WORDS)+1:2].
REQ-009 op_in  input  1  0 = CACHE_READ, 1 = CACHE_WRITE.
REQ-010 write_data_in  input  32  store data; ignored for reads.
REQ-011 valid_out  output  1  read response present on data_out.
REQ-012 ready_out  input  1  requester can consume the response this cycle.
REQ-013 data_out  output  32  read data of the oldest pending response.

Function
REQ-014 Request accepted on an edge where valid_in & ready_in; at most one per cycle.
REQ-015 ready_in SHALL be 1 iff (reads in latency pipeline + FIFO occupancy) < RESP_QDEPTH; independent of op_in and of valid_in.
REQ-016 Accepted write updates the array at the acceptance edge; no response is generated (posted).
REQ-017 Accepted read samples the array at the acceptance edge; a read accepted the edge after a write to the same word returns the new data.
REQ-018 Read accepted at edge k: its response SHALL enter the FIFO at edge k+LATENCY-1 (k for LATENCY=1), visible on valid_out/data_out from edge k+LATENCY when the FIFO was otherwise empty.
REQ-019 Responses SHALL be returned strictly in acceptance order; none dropped or duplicated.
REQ-020 Response consumed on an edge where valid_out & ready_out; data_out and valid_out stable while valid_out & !ready_out.
REQ-021 valid_out = FIFO non-empty; data_out = FIFO head (don't-care when empty).
REQ-022 Simultaneous FIFO push and pop: occupancy unchanged; push into a full FIFO is impossible by REQ-015.
REQ-023 Address bits above the word index and addr_in[1:0] are ignored (index wraps modulo DEPTH_WORDS).
REQ-024 Credit counter width = clog2(RESP_QDEPTH)+1; no wrap at the full bound.

Reset
REQ-025 While reset is high: ready_in = 0, valid_out = 0; pipeline valid bits cleared, FIFO pointers and occupancy cleared.
REQ-026 First edge after reset deasserts: ready_in = 1.
REQ-027 Reset mid-operation discards all in-flight and queued reads; array contents are not reset and are preserved.

Structure
REQ-028 Shared package holds CACHE_READ/CACHE_WRITE constants and the 32-bit word typedef, shared with the CPU pipeline.
REQ-029 Response FIFO is one sub-module, resp_fifo (sync, parameterised width/depth, full/empty/count outputs).
REQ-030 Latency pipeline is a valid+data shift register of LATENCY-1 stages inside mem_responder.

Verification
REQ-031 Write 0xDEADBEEF to 0x10, next cycle read 0x10, ready_out=1 -> valid_out high 2 edges after read acceptance, data_out=0xDEADBEEF.
REQ-032 Back-to-back reads of 0x0,0x4,0x8,0xC (preloaded 1,2,3,4), ready_out=0 -> 4 accepted, then ready_in=0; release ready_out -> data 1,2,3,4 in order, one per cycle.
REQ-033 FIFO full, ready_out=1 and valid_in=1 same cycle -> one pop; ready_in returns to 1 the following cycle; new read accepted; count never exceeds 4.
REQ-034 Read address 0x1000 with DEPTH_WORDS=1024 -> returns contents of word 0.
REQ-035 Two reads in flight, assert reset one cycle -> valid_out=0 during reset and after; no stale response emitted; prior-written data still readable.
REQ-036 Random mix of 1000 reads/writes with random valid_in/ready_out stalls -> data_out matches reference memory model, order preserved, no protocol violation.
